// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer (CTRL/PRESET/COUNT/STATUS/PS), sticky expiry flag, maskable irq.
// Latency: register writes land on the sel&we edge; rdata and irq are combinational, zero added cycles.
// Backpressure: none, the bus is single-cycle and always accepted. Optional prescaler: TIMER_PRESCALE_EN.
module mmio_timer #(
   parameter int WIDTH    = 32,
   parameter int PS_WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic        we,
   input  logic [2:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_CNT,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic             ctrl_en, ctrl_mode, ctrl_im;
   logic             flag;
   logic [WIDTH-1:0] preset;
   logic [WIDTH-1:0] count;

   logic wr, ctrl_wr, preset_wr, count_wr, status_wr;
   logic tick, expire, stopped;

   assign wr        = sel & we;
   assign ctrl_wr   = wr & (addr == 3'd0);
   assign preset_wr = wr & (addr == 3'd1);
   assign count_wr  = wr & (addr == 3'd2);
   assign status_wr = wr & (addr == 3'd3);

   assign stopped = (state == S_IDLE) || (state == S_DONE);
   // COUNT==0 also expires so that PRESET=0 still produces one flag per load.
   assign expire  = (state == S_CNT) && tick && (count <= WIDTH'(1));
   assign irq     = flag & ctrl_im;

`ifdef TIMER_PRESCALE_EN
   logic [PS_WIDTH-1:0] ps;
   logic [PS_WIDTH-1:0] ps_cnt;
   logic                ps_wr;

   assign ps_wr = wr & (addr == 3'd4);
   assign tick  = (ps_cnt == ps);

   // Prescale register, software writable at any time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ps <= '0;
      else if (ps_wr) ps <= wdata[PS_WIDTH-1:0];
   end

   // Prescale counter runs 0..PS while counting and restarts on every load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ps_cnt <= '0;
      else if (state == S_LOAD) ps_cnt <= '0;
      else if (state == S_CNT) ps_cnt <= tick ? '0 : ps_cnt + PS_WIDTH'(1);
   end
`else
   assign tick = 1'b1;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next state; a disabling CTRL write or an accepted COUNT write overrides everything.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (ctrl_wr && wdata[0]) state_nxt = S_LOAD;
         S_LOAD:         state_nxt = S_CNT;
         S_CNT:          if (expire) state_nxt = ctrl_mode ? S_LOAD : S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
      if (ctrl_wr && !wdata[0])  state_nxt = S_IDLE;
      else if (count_wr && stopped) state_nxt = S_IDLE;
   end

   // CTRL: software write wins; a one-shot expiry drops EN so it reads back 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_en   <= 1'b0;
         ctrl_mode <= 1'b0;
         ctrl_im   <= 1'b0;
      end else if (ctrl_wr) begin
         ctrl_en   <= wdata[0];
         ctrl_mode <= wdata[1];
         ctrl_im   <= wdata[2];
      end else if (expire && !ctrl_mode) begin
         ctrl_en   <= 1'b0;
      end
   end

   // PRESET: only sampled at LOAD, so writes mid-count affect the next period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) preset <= '0;
      else if (preset_wr) preset <= wdata[WIDTH-1:0];
   end

   // COUNT: reload, decrement on tick, or software write while stopped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (state == S_LOAD) begin
         count <= preset;
      end else if (state == S_CNT) begin
         if (tick) count <= (count > WIDTH'(1)) ? count - WIDTH'(1) : '0;
      end else if (count_wr) begin
         count <= wdata[WIDTH-1:0];
      end
   end

   // Sticky FLAG: expiry beats a same-edge software clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) flag <= 1'b0;
      else if (expire) flag <= 1'b1;
      else if (status_wr && wdata[0]) flag <= 1'b0;
   end

   // Read mux from live register values; zero when not selected.
   always_comb begin
      rdata = '0;
      if (sel) begin
         case (addr)
            3'd0:    rdata = {29'd0, ctrl_im, ctrl_mode, ctrl_en};
            3'd1:    rdata = 32'(preset);
            3'd2:    rdata = 32'(count);
            3'd3:    rdata = {30'd0, (state == S_DONE), flag};
`ifdef TIMER_PRESCALE_EN
            3'd4:    rdata = 32'(ps);
`endif
            default: rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: stimulus pushes expected read results, a negedge monitor pops and compares.
// Reference model tracks the running period in closed form (count = P - elapsed/(PS+1)).
// No backpressure on the bus; every non-write cycle produces exactly one scoreboard entry.
module tb_mmio_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        we;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   mmio_timer dut (
      .clk   (clk),
      .rst   (rst),
      .sel   (sel),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        irq;
      logic [2:0]  addr;
      logic        sel;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_on  = 1'b0;

   // ---------------- reference model ----------------
   localparam int P_IDLE = 0, P_ARMED = 1, P_RUN = 2, P_DONE = 3;
   int     ph;
   bit     m_en, m_mode, m_im, m_flag;
   longint m_preset, m_count, m_ps;
   longint run_p, run_ps, run_l, run_e, edge_n;

   function automatic void model_reset();
      ph = P_IDLE;
      m_en = 0; m_mode = 0; m_im = 0; m_flag = 0;
      m_preset = 0; m_count = 0; m_ps = 0;
      run_p = 0; run_ps = 0; run_l = 0; run_e = 0; edge_n = 0;
   endfunction

   // Advance the model by one clock edge carrying bus op (s,w,a,d).
   function automatic void model_edge(input bit s, input bit w, input int a, input logic [31:0] d);
      int     pre = ph;
      bit     expire = 0;
      longint k;
      edge_n++;
      if (ph == P_ARMED) begin
         run_p   = m_preset;
         run_ps  = m_ps;
         run_l   = edge_n;
         run_e   = run_l + ((run_p == 0) ? 1 : run_p) * (run_ps + 1);
         m_count = run_p;
         ph      = P_RUN;
      end else if (ph == P_RUN) begin
         k = (edge_n - run_l) / (run_ps + 1);
         m_count = (run_p > k) ? run_p - k : 0;
         if (edge_n == run_e) begin
            expire = 1;
            m_flag = 1;
            if (m_mode) ph = P_ARMED;
            else begin
               ph   = P_DONE;
               m_en = 0;
            end
         end
      end
      if (s && w) begin
         case (a)
            0: begin
               m_en = d[0]; m_mode = d[1]; m_im = d[2];
               if (!d[0]) ph = P_IDLE;
               else if (pre == P_IDLE || pre == P_DONE) ph = P_ARMED;
            end
            1: m_preset = {32'd0, d};
            2: if (pre == P_IDLE || pre == P_DONE) begin
                  m_count = {32'd0, d};
                  ph = P_IDLE;
               end
            3: if (d[0] && !expire) m_flag = 0;
`ifdef TIMER_PRESCALE_EN
            4: m_ps = {56'd0, d[7:0]};
`endif
            default: ;
         endcase
      end
   endfunction

   function automatic logic [31:0] exp_rdata(input bit s, input int a);
      if (!s) return 32'd0;
      case (a)
         0: return {29'd0, m_im, m_mode, m_en};
         1: return m_preset[31:0];
         2: return m_count[31:0];
         3: return {30'd0, (ph == P_DONE), m_flag};
         4: return m_ps[31:0];
         default: return 32'd0;
      endcase
   endfunction

   // Drive one bus cycle starting just after a rising edge; returns just after the next one.
   task automatic bus(input bit s, input bit w, input int a, input logic [31:0] d);
      exp_t e;
      sel = s; we = w; addr = 3'(a); wdata = d;
      if (!(s && w)) begin
         e.rdata = exp_rdata(s, a);
         e.irq   = m_flag & m_im;
         e.addr  = 3'(a);
         e.sel   = s;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      model_edge(s, w, a, d);
   endtask

   task automatic rd(input int a);
      bus(1'b1, 1'b0, a, 32'd0);
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      bus(1'b1, 1'b1, a, d);
   endtask

   task automatic push_exp(input logic [31:0] r, input logic i);
      exp_t e;
      e.rdata = r; e.irq = i; e.addr = addr; e.sel = sel;
      sb_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (mon_on && !(sel && we)) begin
         exp_t e;
         if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_empty: no expected entry, rdata=%h irq=%b", rdata, irq);
         end else begin
            e = sb_q.pop_front();
            n_tests++;
            if (rdata !== e.rdata) begin
               n_fail++;
               $display("FAIL rdata sel=%b addr=%0d @%0t: got %h expected %h", e.sel, e.addr, $time, rdata, e.rdata);
            end
            n_tests++;
            if (irq !== e.irq) begin
               n_fail++;
               $display("FAIL irq @%0t: got %b expected %b", $time, irq, e.irq);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; sel = 1'b0; we = 1'b0; addr = 3'd0; wdata = 32'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      mon_on = 1'b1;

      // Reset state: every offset reads 0, deselected bus reads 0.
      for (int a = 0; a < 8; a++) rd(a);
      bus(1'b0, 1'b0, 2, 32'd0);

      // One-shot with IM: COUNT 5..0, then FLAG/DONE, EN reads 0.
      wr(1, 32'd5);
      wr(0, 32'b101);
      for (int i = 0; i < 8; i++) rd(2);
      rd(3);
      rd(0);
      wr(3, 32'd1);
      rd(3);

      // Auto-reload P=3, clear on non-expiry and on expiry edges.
      wr(1, 32'd3);
      wr(0, 32'b111);
      for (int i = 0; i < 10; i++) rd(i % 2 == 0 ? 2 : 3);
      for (int i = 0; i < 10 && (ph == P_RUN && run_e == edge_n + 1); i++) rd(3);
      wr(3, 32'd1);
      rd(3);
      rd(3);
      for (int i = 0; i < 10 && !(ph == P_RUN && run_e == edge_n + 1); i++) rd(2);
      wr(3, 32'd1);
      rd(3);
      rd(3);

      // COUNT write ignored while counting; disable freezes; re-enable reloads PRESET.
      wr(2, 32'd100);
      rd(2);
      wr(0, 32'd0);
      rd(2); rd(2); rd(0);
      wr(2, 32'd7);
      rd(2);
      wr(0, 32'b001);
      for (int i = 0; i < 6; i++) rd(2);
      wr(0, 32'd0);
      wr(3, 32'd1);

      // PRESET=0, IM=0: FLAG two edges after enable, irq stays low.
      wr(1, 32'd0);
      wr(0, 32'b001);
      for (int i = 0; i < 4; i++) rd(3);
      wr(3, 32'd1);

      // Prescaler: PS=2, PRESET=2 (offset 4 reads 0 when the feature is absent).
      wr(4, 32'd2);
      rd(4);
      wr(1, 32'd2);
      wr(0, 32'b101);
      for (int i = 0; i < 10; i++) rd(3);
      wr(0, 32'd0);
      wr(4, 32'd0);
      wr(3, 32'd1);

      // Writes to unmapped offsets are ignored.
      wr(5, 32'hFFFF_FFFF);
      wr(7, 32'hFFFF_FFFF);
      rd(5); rd(7); rd(0);

      // Asynchronous reset mid-count with COUNT=5.
      wr(1, 32'd9);
      wr(0, 32'b101);
      for (int i = 0; i < 20 && !(ph == P_RUN && m_count == 5); i++) rd(2);
      rst = 1'b1;
      model_reset();
      sel = 1'b1; we = 1'b0; addr = 3'd2;
      push_exp(32'd0, 1'b0);
      @(posedge clk); #1;
      addr = 3'd3;
      push_exp(32'd0, 1'b0);
      @(posedge clk); #1;
      addr = 3'd0;
      push_exp(32'd0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         int r = $urandom_range(0, 99);
         if (r < 45)      rd($urandom_range(0, 7));
         else if (r < 50) bus(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom);
         else if (r < 60) wr(0, {$urandom} & 32'hFFFF_FFF8 | 32'($urandom_range(0, 7)) | 32'(($urandom_range(0, 3) != 0)));
         else if (r < 68) wr(1, 32'($urandom_range(0, 6)));
         else if (r < 76) wr(2, 32'($urandom_range(0, 200)));
         else if (r < 88) wr(3, 32'($urandom_range(0, 3)));
         else if (r < 92) begin
            if (ph == P_IDLE || ph == P_DONE) wr(4, 32'($urandom_range(0, 3)));
            else rd(4);
         end else wr($urandom_range(5, 7), $urandom);
      end

      mon_on = 1'b0;
      sel = 1'b0; we = 1'b0;
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped down-counting timer on the single-cycle CPU data bus, alongside the data memory. The system decoder asserts `sel` when the CPU's data address falls in the timer window. The CPU then reads and writes five word registers to arm one-shot or auto-reload countdowns. On expiry the block raises a sticky flag and a maskable `irq` line.

## Interface
- `WIDTH`, 32, width of PRESET/COUNT registers (≤32, zero-extended on read)
- `PS_WIDTH`, 8, prescaler width (used only with TIMER_PRESCALE_EN)
- `clk`  in  1  CPU clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `sel`  in  1  chip select from address decoder
- `we`  in  1  write strobe (CPU MemWrite), qualified by `sel`
- `addr`  in  3  word offset, dm_addr[4:2]
- `wdata`  in  32  write data (CPU writedata)
- `rdata`  out  32  combinational read data; 0 when `sel`=0
- `irq`  out  1  interrupt, = FLAG & CTRL.IM

## Operation
- Register map (word offset):
  - 0 CTRL: [0] EN, [1] MODE (0 one-shot, 1 auto-reload), [2] IM.
  - 1 PRESET.
  - 2 COUNT.
  - 3 STATUS: [0] FLAG, [1] DONE. Write 1 to bit 0 clears FLAG.
  - 4 PS (prescaler).
  - 5–7 read 0, writes ignored.
- Writes take effect on the rising edge where `sel & we`.
- States:
  - IDLE: counter stopped. COUNT writable. CTRL write with EN=1 → LOAD.
  - LOAD: one cycle. COUNT←PRESET, prescale counter←0 → CNT.
  - CNT: on each tick, if COUNT>1 then COUNT−1. If COUNT==1, or COUNT==0 (PRESET=0 case), then COUNT←0 and FLAG←1. After expiry, MODE=1 → LOAD; MODE=0 → DONE and EN←0.
  - DONE: counter stopped, STATUS.DONE=1. CTRL write with EN=1 → LOAD.
- CTRL write with EN=0 from any state → IDLE next edge. COUNT holds its value.
- COUNT writes are honoured only in IDLE and DONE (state → IDLE). They are ignored in LOAD and CNT.
- PRESET writes in CNT affect only the next LOAD.
- FLAG set and software clear on the same edge: set wins.
- `rdata` mux is driven by the current register values. CTRL.EN reads its live value.
- Reset values: CTRL=0, PRESET=0, COUNT=0, PS=0, FLAG=0, state IDLE, `irq`=0, `rdata`=0 (while `sel`=0).
- Reset asserted mid-count returns all of the above immediately, without waiting for a clock edge.

## Timing
- Prescaler off: tick every cycle.
- EN=1 written at edge N:
  - Edge N+1: COUNT=PRESET=P.
  - Edge N+1+P: FLAG=1 and `irq`=1 (if IM).
  - For P=0: FLAG at edge N+2.
- Auto-reload period is P+1 cycles between successive FLAG-set edges (for P≥1).
- `irq` is combinational from registered FLAG and IM, with no extra latency.
- `rdata` is valid in the same cycle as `sel`/`addr`, matching single-cycle load timing.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - Offset 4 holds a PS_WIDTH-bit PS register.
  - The prescale counter counts 0..PS; a tick is issued when it equals PS, then it wraps to 0.
  - Tick every PS+1 cycles, so expiry at edge N+1+(P·(PS+1)).
- Not defined: tick every cycle, offset 4 reads 0, writes ignored, no prescaler flops.

## Test plan
- Reset then read offsets 0–7 → all 0, `irq`=0. Assert `rst` mid-CNT with COUNT=5 → COUNT=0, FLAG=0, IDLE immediately.
- PRESET=5, CTRL=0b101 (EN, one-shot, IM) at edge N → COUNT 5,4,3,2,1,0 at edges N+1..N+6. `irq`=1 from N+6, STATUS=0b11, CTRL.EN reads 0.
- PRESET=3, CTRL=0b111 → FLAG-set edges spaced 4 cycles apart. Write STATUS=1 on a non-expiry edge → `irq` drops the next cycle. Write STATUS=1 on an expiry edge → FLAG stays 1.
- In CNT, write COUNT=100 → ignored. Write CTRL=0 → IDLE, COUNT frozen. Write COUNT=7, then CTRL EN → reload from PRESET, not 7.
- PRESET=0, EN → FLAG at edge N+2. With IM=0, FLAG=1 but `irq`=0.
- With TIMER_PRESCALE_EN: PS=2, PRESET=2, EN at edge N → FLAG at edge N+7. Without the macro: write offset 4 = 2, read back → 0.
